hazard_scheduler: RTL and testbench



---
 rtl/hazard_scheduler.sv | 119 +++++++++++
 tb/tb_hazard_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Interlock and flush controller for the 16-bit 5-stage CPU: decodes IF/ID,
// tracks in-flight register writes in an EX/MEM/WB shadow scoreboard.
module hazard_scheduler (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ifid_ir,
  input  logic        exmem_branch,
  input  logic        exmem_branch_type,
  input  logic        exmem_zero,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_flush,
  output logic        br_taken,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef struct packed {
    logic       valid;
    logic [1:0] dest;
  } slot_t;

  slot_t      slot_ex, slot_mem, slot_wb;

  logic [3:0] op;
  logic [1:0] rs, rt, rd;
  logic       use_rs, use_rt, writes;
  logic [1:0] dest;
  logic       hazard;
  logic       issue;
  logic       unused_ir;

  assign op        = ifid_ir[15:12];
  assign rs        = ifid_ir[11:10];
  assign rt        = ifid_ir[9:8];
  assign rd        = ifid_ir[7:6];
  assign unused_ir = ^ifid_ir[5:0];

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    writes = 1'b0;
    dest   = '0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        writes = 1'b1;
        dest   = rd;
      end
      4'h7, 4'h8: begin
        use_rs = 1'b1;
        writes = 1'b1;
        dest   = rt;
      end
      4'h9, 4'hA, 4'hB: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // Register 0 is hardwired, so it can never be the subject of a hazard.
  function automatic logic pending(input logic [1:0] r, input slot_t ex,
                                   input slot_t mem, input slot_t wb);
    return (r != 2'd0) &&
           ((ex.valid  && ex.dest  == r) ||
            (mem.valid && mem.dest == r) ||
            (wb.valid  && wb.dest  == r));
  endfunction

  assign hazard = (use_rs && pending(rs, slot_ex, slot_mem, slot_wb)) ||
                  (use_rt && pending(rt, slot_ex, slot_mem, slot_wb));

  assign br_taken = exmem_branch &
                    (exmem_branch_type ? ~exmem_zero : exmem_zero);

  assign issue = ~br_taken & ~hazard & writes & (dest != 2'd0);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // A taken branch squashes the instruction leaving ID/EX, so its write never lands.
  always_ff @(negedge clock) begin
    if (reset) begin
      slot_ex     <= '0;
      slot_mem    <= '0;
      slot_wb     <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      slot_wb  <= slot_mem;
      slot_mem <= br_taken ? slot_t'('0) : slot_ex;
      slot_ex  <= '{valid: issue, dest: dest};
      if (hazard && !br_taken && stall_count != '1)
        stall_count <= stall_count + 16'd1;
      if (br_taken && flush_count != '1)
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed scenarios followed by
// random traffic, compared against an age-list model of pending writes.
module tb_hazard_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] ifid_ir;
  logic        exmem_branch, exmem_branch_type, exmem_zero;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, br_taken;
  logic [15:0] stall_count, flush_count;

  int checks = 0;
  int failures = 0;

  hazard_scheduler dut (
    .clock(clock), .reset(reset), .ifid_ir(ifid_ir),
    .exmem_branch(exmem_branch), .exmem_branch_type(exmem_branch_type),
    .exmem_zero(exmem_zero), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .br_taken(br_taken), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  // Model: list of writes still invisible to a reader; age 1 = EX, 2 = MEM, 3 = WB.
  typedef struct { int r; int age; } wr_t;
  wr_t wq[$];
  int  m_stall = 0;
  int  m_flush = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void decode(input logic [15:0] ir, output bit rd_s, output bit rd_t,
                                 output bit wr, output int dst);
    int op, s, t, d;
    op = int'(ir[15:12]); s = int'(ir[11:10]); t = int'(ir[9:8]); d = int'(ir[7:6]);
    rd_s = 0; rd_t = 0; wr = 0; dst = 0;
    if (op <= 6) begin rd_s = 1; rd_t = 1; wr = 1; dst = d; end
    else if (op <= 8) begin rd_s = 1; wr = 1; dst = t; end
    else if (op <= 11) begin rd_s = 1; rd_t = 1; end
  endfunction

  function automatic bit is_pending(input int r);
    if (r == 0) return 0;
    foreach (wq[i]) if (wq[i].r == r) return 1;
    return 0;
  endfunction

  task automatic step(input bit rst, input logic [15:0] ir, input bit b, input bit bt,
                      input bit z, input string tag);
    bit rd_s, rd_t, wr, hz, br;
    int dst;
    logic [5:0] exp_ctl;
    wr_t nq[$];
    @(posedge clock);
    reset = rst; ifid_ir = ir;
    exmem_branch = b; exmem_branch_type = bt; exmem_zero = z;
    #1;
    decode(ir, rd_s, rd_t, wr, dst);
    hz = (rd_s && is_pending(int'(ir[11:10]))) || (rd_t && is_pending(int'(ir[9:8])));
    br = b && (bt ? !z : z);
    if (br)      exp_ctl = 6'b111111;
    else if (hz) exp_ctl = 6'b000100;
    else         exp_ctl = 6'b110000;
    check({tag, ".ctl"}, 16'({pc_write, ifid_write, ifid_flush, idex_bubble,
                              exmem_flush, br_taken}), 16'(exp_ctl));
    @(negedge clock);
    if (rst) begin
      wq.delete(); m_stall = 0; m_flush = 0;
    end else begin
      if (hz && !br && m_stall < 65535) m_stall++;
      if (br && m_flush < 65535) m_flush++;
      foreach (wq[i])
        if (!(br && wq[i].age == 1) && wq[i].age < 3)
          nq.push_back('{wq[i].r, wq[i].age + 1});
      if (!br && !hz && wr && dst != 0) nq.push_back('{dst, 1});
      wq = nq;
    end
    #1;
    check({tag, ".stall_count"}, stall_count, 16'(m_stall));
    check({tag, ".flush_count"}, flush_count, 16'(m_flush));
  endtask

  task automatic ins(input logic [15:0] ir, input string tag);
    step(0, ir, 0, 0, 0, tag);
  endtask

  task automatic drain();
    repeat (3) ins(16'h0000, "drain");
  endtask

  initial begin
    int base_s, base_f;
    logic [15:0] rir;
    reset = 1'b1; ifid_ir = 16'h8100;
    exmem_branch = 1'b0; exmem_branch_type = 1'b0; exmem_zero = 1'b0;
    repeat (2) @(negedge clock);
    step(1, 16'h8100, 0, 0, 0, "reset_hold");
    check("reset_stall0", stall_count, 16'h0000);
    check("reset_flush0", flush_count, 16'h0000);
    ins(16'h8100, "post_reset");
    check("post_reset_pcw", 16'(pc_write), 16'h0001);

    base_s = m_stall;
    ins(16'h8204, "raw_lw");
    repeat (4) ins(16'h66C0, "raw_slt");
    check("raw_three_stalls", stall_count, 16'(base_s + 3));
    drain();

    base_s = m_stall;
    ins(16'h8204, "indep_lw");
    ins(16'h7501, "indep_rd1");
    ins(16'h0000, "zero_a");
    ins(16'h0000, "zero_b");
    check("indep_no_stall", stall_count, 16'(base_s));
    drain();

    base_s = m_stall;
    ins(16'h8204, "gap2_lw");
    ins(16'h0000, "gap2_nop");
    ins(16'h0000, "gap2_nop");
    repeat (2) ins(16'h66C0, "gap2_slt");
    check("gap2_one_stall", stall_count, 16'(base_s + 1));
    drain();

    base_f = m_flush;
    step(0, 16'h0000, 1, 0, 1, "beq_taken");
    check("beq_flush_cnt", flush_count, 16'(base_f + 1));
    step(0, 16'h0000, 1, 1, 1, "bne_not_taken");
    step(0, 16'h0000, 1, 1, 0, "bne_taken");
    check("bne_flush_cnt", flush_count, 16'(base_f + 2));
    drain();

    base_s = m_stall;
    base_f = m_flush;
    ins(16'h8204, "squash_lw");
    step(0, 16'h66C0, 1, 0, 1, "squash_br");
    check("squash_pcw", 16'(pc_write), 16'h0001);
    ins(16'h66C0, "squash_after");
    check("squash_after_pcw", 16'(pc_write), 16'h0001);
    check("squash_stall_unch", stall_count, 16'(base_s));
    check("squash_flush_inc", flush_count, 16'(base_f + 1));
    drain();

    ins(16'h8204, "mid_reset_lw");
    ins(16'h66C0, "mid_reset_stall");
    step(1, 16'h66C0, 0, 0, 0, "mid_reset_assert");
    ins(16'h66C0, "mid_reset_release");
    check("mid_reset_pcw", 16'(pc_write), 16'h0001);

    for (int i = 0; i < 600; i++) begin
      bit b, bt, z, r;
      rir = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0);
      bt = 1'($urandom);
      z  = 1'($urandom);
      r  = ($urandom_range(0, 99) == 0);
      step(r, rir, b, bt, z, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
